lsu_agen_pro: RTL and testbench
===============================

// Module: lsu_agen_pro
// PURPOSE
//  Parametrised next-generation load/store unit for the CGRA array: N-PE store mux,
//  depth-configurable instruction buffer with programmed-length looping, and a
//  runtime-configurable 2-D address generator (alpha/beta/num loaded by cfg port).
//  Sits between the PE columns and the CBG memory crossbar; issues R/W requests,
//  returns registered load data with a valid flag.
// PARAMETERS
//  DATA_W    32  data width of PE, load and store paths
//  ADDR_W    16  generated address width
//  NUM_PE    4   number of PE inputs to the store mux (>=2)
//  BUF_DEPTH 16  instruction buffer entries (power of 2)
//  PSEL_W    $clog2(NUM_PE) pe_sel field width (derived, localparam)
//  INST_W    10+PSEL_W  instruction width {ren,wen,r_sel[1:0],w_sel[1:0],addr_sel[1:0],pe_sel,store_sel,last}
// PORTS
//  clk          in  1               clock
//  rst          in  1               asynchronous reset, active-high
//  init         in  1               write inst_in to buffer[wr_ptr]
//  inst_in      in  INST_W          instruction word during init
//  run          in  1               step one instruction per cycle
//  cfg_we       in  1               load AG config and clear AG counters
//  cfg_alpha    in  ADDR_W          outer (row) stride
//  cfg_beta     in  ADDR_W          inner (column) stride
//  cfg_num      in  ADDR_W          inner trip count (0 treated as 1)
//  pe_data      in  NUM_PE*DATA_W   PE outputs, PE k at [k*DATA_W +: DATA_W]
//  rd_valid     in  1               memory read data valid (from CBG)
//  rd_data      in  DATA_W          memory read data
//  r_request    out 3               {r_sel[1:0], ren}
//  w_request    out 3+DATA_W        {w_sel[1:0], wen, store_data}
//  addr_bus     out 2+ADDR_W        {addr_sel[1:0], addr}
//  lsu_to_pe    out DATA_W          registered load data
//  load_valid   out 1               lsu_to_pe updated last cycle
//  prog_done    out 1               1-cycle pulse when an inst with last=1 issues
// BEHAVIOUR
//  Reset: buffer, wr_ptr, rd_ptr, prog_len, inst_r, AG regs (alpha/beta/num, i/j) = 0;
//   lsu_to_pe = store_data = all ones; load_valid = prog_done = 0.
//  Priority: init > run. init: buffer[wr_ptr]<=inst_in, wr_ptr++ (wraps at BUF_DEPTH),
//   prog_len<=min(wr_ptr+1,BUF_DEPTH). init clears rd_ptr to 0.
//  run: inst_r<=buffer[rd_ptr] (1-cycle latency run->request); rd_ptr++ and wraps to 0
//   after prog_len-1 or after an entry with last=1. run low: inst_r<=0 (NOP, no req).
//  prog_len==0 with run: inst_r<=0, rd_ptr held.
//  Request outputs decode inst_r combinationally; ren/wen/selects are zero when inst_r=0.
//  AG: addr = base_i + off_j (mod 2^ADDR_W). Each cycle with ren|wen:
//   j_cnt==num_eff-1 -> j_cnt=0, off_j=0, base_i+=alpha; else j_cnt++, off_j+=beta.
//   num_eff = (num==0)?1:num. Address advances after the access it served.
//  cfg_we: latch alpha/beta/num, clear base_i/off_j/j_cnt; wins over same-cycle advance.
//  Load: rd_valid=1 -> lsu_to_pe<=rd_data, load_valid<=1; else hold data, load_valid<=0.
//  Store: every cycle store_data <= store_sel ? lsu_to_pe : pe_data[pe_sel];
//   pe_sel >= NUM_PE selects zero.
//  prog_done: registered alongside inst_r when fetched entry has last=1 under run.
//  Async rst mid-run: all state returns to reset values immediately; buffer contents lost.
// TESTING
//  T1 reset: assert rst mid-run -> r/w requests 0, lsu_to_pe=32'hFFFFFFFF, load_valid=0.
//  T2 init 3 insts (ren=1,r_sel=1 / wen=1 / last=1), run 7 cycles -> issue order
//     0,1,2,0,1,2,0 one cycle after run; prog_done pulses on cycles 3 and 6.
//  T3 cfg alpha=100,beta=4,num=3, 7 accesses -> addr 0,4,8,100,104,108,200.
//  T4 cfg num=0, alpha=8 -> addr 0,8,16; beta=0xFFFF,num=2 from base 0 -> 0,0xFFFF wrap ok.
//  T5 store mux NUM_PE=4: pe_sel=2, pe_data[2]=0xA5A5A5A5 -> store_data 0xA5A5A5A5
//     next cycle; store_sel=1 after rd_valid/rd_data=0x1234 -> store_data 0x1234.
//  T6 cfg_we same cycle as ren -> addr next cycle 0, j_cnt 0; init+run same cycle -> init only.

Source files
------------

// File: rtl/lsu_agen_pro.sv
// lsu_agen_pro: load/store unit for the CGRA array. Holds a small looping
// instruction program, decodes the current instruction into read/write
// requests toward the CBG crossbar, generates 2-D strided addresses, muxes
// PE outputs onto the store path and registers returning load data.
module lsu_agen_pro #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 16,
  parameter int NUM_PE    = 4,
  parameter int BUF_DEPTH = 16,
  localparam int PSEL_W   = $clog2(NUM_PE),
  localparam int INST_W   = 10 + PSEL_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     init,
  input  logic [INST_W-1:0]        inst_in,
  input  logic                     run,
  input  logic                     cfg_we,
  input  logic [ADDR_W-1:0]        cfg_alpha,
  input  logic [ADDR_W-1:0]        cfg_beta,
  input  logic [ADDR_W-1:0]        cfg_num,
  input  logic [NUM_PE*DATA_W-1:0] pe_data,
  input  logic                     rd_valid,
  input  logic [DATA_W-1:0]        rd_data,
  output logic [2:0]               r_request,
  output logic [DATA_W+2:0]        w_request,
  output logic [ADDR_W+1:0]        addr_bus,
  output logic [DATA_W-1:0]        lsu_to_pe,
  output logic                     load_valid,
  output logic                     prog_done
);

  localparam int PTR_W = $clog2(BUF_DEPTH);

  logic [INST_W-1:0] buffer [BUF_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    prog_len;
  logic [INST_W-1:0] inst_r;
  logic [INST_W-1:0] fetch;
  logic              fetch_wrap;

  // Instruction field decode of the issued instruction
  logic              ren, wen, store_sel;
  logic [1:0]        r_sel, w_sel, addr_sel;
  logic [PSEL_W-1:0] pe_sel;

  assign ren       = inst_r[INST_W-1];
  assign wen       = inst_r[INST_W-2];
  assign r_sel     = inst_r[PSEL_W+7:PSEL_W+6];
  assign w_sel     = inst_r[PSEL_W+5:PSEL_W+4];
  assign addr_sel  = inst_r[PSEL_W+3:PSEL_W+2];
  assign pe_sel    = inst_r[PSEL_W+1:2];
  assign store_sel = inst_r[1];

  // Loop back to entry 0 after the last programmed entry or a last-flagged one
  assign fetch      = buffer[rd_ptr];
  assign fetch_wrap = fetch[0] || ({1'b0, rd_ptr} == prog_len - 1'b1);

  // Program load (init) and instruction issue (run); init has priority
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the buffer is cleared on reset because a program must not survive
      // a reset; a plain RAM without reset would keep stale instructions.
      for (int k = 0; k < BUF_DEPTH; k++) buffer[k] <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      prog_len  <= '0;
      inst_r    <= '0;
      prog_done <= 1'b0;
    end else if (init) begin
      buffer[wr_ptr] <= inst_in;
      wr_ptr         <= wr_ptr + 1'b1;
      prog_len       <= {1'b0, wr_ptr} + 1'b1;
      rd_ptr         <= '0;
      inst_r         <= '0;
      prog_done      <= 1'b0;
    end else if (run && prog_len != '0) begin
      inst_r    <= fetch;
      prog_done <= fetch[0];
      rd_ptr    <= fetch_wrap ? '0 : rd_ptr + 1'b1;
    end else begin
      inst_r    <= '0;
      prog_done <= 1'b0;
    end
  end

  // 2-D address generator state
  logic [ADDR_W-1:0] alpha, beta, num, num_eff;
  logic [ADDR_W-1:0] base_i, off_j, j_cnt;

  assign num_eff = (num == '0) ? ADDR_W'(1) : num;

  // Advance after each served access; a config write restarts the pattern
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alpha  <= '0;
      beta   <= '0;
      num    <= '0;
      base_i <= '0;
      off_j  <= '0;
      j_cnt  <= '0;
    end else if (cfg_we) begin
      alpha  <= cfg_alpha;
      beta   <= cfg_beta;
      num    <= cfg_num;
      base_i <= '0;
      off_j  <= '0;
      j_cnt  <= '0;
    end else if (ren || wen) begin
      if (j_cnt == num_eff - 1'b1) begin
        j_cnt  <= '0;
        off_j  <= '0;
        base_i <= base_i + alpha;
      end else begin
        j_cnt <= j_cnt + 1'b1;
        off_j <= off_j + beta;
      end
    end
  end

  // Store source select; out-of-range PE indices yield zero
  logic [DATA_W-1:0] pe_mux;
  always_comb begin
    // NOTE: default first so every path assigns pe_mux and no latch is inferred.
    pe_mux = '0;
    for (int k = 0; k < NUM_PE; k++) begin
      if (PSEL_W'(k) == pe_sel) pe_mux = pe_data[k*DATA_W +: DATA_W];
    end
  end

  logic [DATA_W-1:0] store_data;

  // Load data capture and store data registration
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lsu_to_pe  <= '1;
      load_valid <= 1'b0;
      store_data <= '1;
    end else begin
      if (rd_valid) lsu_to_pe <= rd_data;
      load_valid <= rd_valid;
      store_data <= store_sel ? lsu_to_pe : pe_mux;
    end
  end

  assign r_request = {r_sel, ren};
  assign w_request = {w_sel, wen, store_data};
  assign addr_bus  = {addr_sel, base_i + off_j};

endmodule

// File: tb/tb_lsu_agen_pro.sv
// Self-checking bench for lsu_agen_pro: stimulus pushes expected outputs into
// a scoreboard queue; a negedge monitor pops and compares them.
module tb_lsu_agen_pro;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 16;
  localparam int NUM_PE = 4;
  localparam int INST_W = 12;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     init = 1'b0;
  logic [INST_W-1:0]        inst_in = '0;
  logic                     run = 1'b0;
  logic                     cfg_we = 1'b0;
  logic [ADDR_W-1:0]        cfg_alpha = '0, cfg_beta = '0, cfg_num = '0;
  logic [NUM_PE*DATA_W-1:0] pe_data = '0;
  logic                     rd_valid = 1'b0;
  logic [DATA_W-1:0]        rd_data = '0;
  logic [2:0]               r_request;
  logic [DATA_W+2:0]        w_request;
  logic [ADDR_W+1:0]        addr_bus;
  logic [DATA_W-1:0]        lsu_to_pe;
  logic                     load_valid;
  logic                     prog_done;

  lsu_agen_pro dut (
    .clk(clk), .rst(rst), .init(init), .inst_in(inst_in), .run(run),
    .cfg_we(cfg_we), .cfg_alpha(cfg_alpha), .cfg_beta(cfg_beta), .cfg_num(cfg_num),
    .pe_data(pe_data), .rd_valid(rd_valid), .rd_data(rd_data),
    .r_request(r_request), .w_request(w_request), .addr_bus(addr_bus),
    .lsu_to_pe(lsu_to_pe), .load_valid(load_valid), .prog_done(prog_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                due;
    logic [2:0]        r;
    logic [2:0]        w;
    logic              d;
    logic              chk_a;
    logic [ADDR_W+1:0] a;
    logic              chk_s;
    logic [DATA_W-1:0] s;
    logic              chk_l;
    logic [DATA_W-1:0] l;
    logic              lv;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare the outputs produced at this cycle with the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      e = sbq.pop_front();
      check("r_request", 64'(r_request), 64'(e.r));
      check("w_ctl", 64'(w_request[DATA_W+2:DATA_W]), 64'(e.w));
      check("prog_done", 64'(prog_done), 64'(e.d));
      if (e.chk_a) check("addr_bus", 64'(addr_bus), 64'(e.a));
      if (e.chk_s) check("store_data", 64'(w_request[DATA_W-1:0]), 64'(e.s));
      if (e.chk_l) begin
        check("lsu_to_pe", 64'(lsu_to_pe), 64'(e.l));
        check("load_valid", 64'(load_valid), 64'(e.lv));
      end
    end
  end

  function automatic logic [INST_W-1:0] mk_inst(input logic ren, input logic wen,
      input logic [1:0] rs, input logic [1:0] ws, input logic [1:0] as,
      input logic [1:0] ps, input logic ss, input logic last);
    return {ren, wen, rs, ws, as, ps, ss, last};
  endfunction

  function automatic exp_t mk_exp(input logic [2:0] r, input logic [2:0] w, input logic d);
    exp_t e;
    e = '{due: 0, r: r, w: w, d: d, chk_a: 1'b0, a: '0, chk_s: 1'b0, s: '0,
          chk_l: 1'b0, l: '0, lv: 1'b0};
    return e;
  endfunction

  // One clock: record expectation for the next edge, then release one-shot inputs
  task automatic step(input exp_t e);
    e.due = cyc + 1;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    init     = 1'b0;
    cfg_we   = 1'b0;
    rd_valid = 1'b0;
  endtask

  task automatic cfg(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b,
                     input logic [ADDR_W-1:0] n);
    cfg_we = 1'b1; cfg_alpha = a; cfg_beta = b; cfg_num = n;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Read access expectation for the looping single-instruction program
  function automatic exp_t rd_exp(input logic [ADDR_W-1:0] a);
    exp_t e;
    e = mk_exp(3'b101, 3'b000, 1'b1);
    e.chk_a = 1'b1;
    e.a = {2'b01, a};
    return e;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cyc %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [ADDR_W-1:0] t3_addr [7];
    logic [ADDR_W-1:0] t4_addr [3];
    exp_t e;
    t3_addr = '{16'd0, 16'd4, 16'd8, 16'd100, 16'd104, 16'd108, 16'd200};
    t4_addr = '{16'd0, 16'd8, 16'd16};
    pe_data = {32'h33330003, 32'hA5A5A5A5, 32'h11110001, 32'h11110000};

    // Power-on reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_r_request", 64'(r_request), 64'd0);
    check("rst_w_request", 64'(w_request), {29'd0, 3'b000, 32'hFFFFFFFF});
    check("rst_lsu_to_pe", 64'(lsu_to_pe), 64'hFFFFFFFF);
    check("rst_load_valid", 64'(load_valid), 64'd0);
    check("rst_prog_done", 64'(prog_done), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Three-entry program looping: 0,1,2,0,1,2,0
    init = 1'b1; inst_in = mk_inst(1, 0, 2'd1, 2'd0, 2'd0, 2'd0, 0, 0); step(mk_exp(0, 0, 0));
    init = 1'b1; inst_in = mk_inst(0, 1, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0); step(mk_exp(0, 0, 0));
    init = 1'b1; inst_in = mk_inst(0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 0, 1); step(mk_exp(0, 0, 0));
    run = 1'b1;
    for (int k = 0; k < 7; k++) begin
      case (k % 3)
        0: begin e = mk_exp(3'b011, 3'b000, 1'b0); e.chk_a = 1'b1; e.a = '0; end
        1: e = mk_exp(3'b000, 3'b001, 1'b0);
        default: e = mk_exp(3'b000, 3'b000, 1'b1);
      endcase
      step(e);
    end
    run = 1'b0; step(mk_exp(0, 0, 0));

    // 2-D addressing: alpha=100, beta=4, num=3
    do_reset();
    init = 1'b1; inst_in = mk_inst(1, 0, 2'd2, 2'd0, 2'd1, 2'd0, 0, 1); step(mk_exp(0, 0, 0));
    cfg(16'd100, 16'd4, 16'd3); step(mk_exp(0, 0, 0));
    run = 1'b1;
    for (int k = 0; k < 7; k++) step(rd_exp(t3_addr[k]));
    run = 1'b0; step(mk_exp(0, 0, 0));

    // num=0 behaves as 1: only alpha steps
    cfg(16'd8, 16'd0, 16'd0); step(mk_exp(0, 0, 0));
    run = 1'b1;
    for (int k = 0; k < 3; k++) step(rd_exp(t4_addr[k]));
    run = 1'b0; step(mk_exp(0, 0, 0));

    // Address wrap modulo 2^ADDR_W
    cfg(16'd0, 16'hFFFF, 16'd2); step(mk_exp(0, 0, 0));
    run = 1'b1;
    step(rd_exp(16'd0));
    step(rd_exp(16'hFFFF));
    run = 1'b0; step(mk_exp(0, 0, 0));

    // cfg_we in the same cycle as an access restarts the pattern
    cfg(16'd0, 16'd5, 16'd4); step(mk_exp(0, 0, 0));
    run = 1'b1;
    step(rd_exp(16'd0));
    step(rd_exp(16'd5));
    cfg(16'd0, 16'd5, 16'd4); step(rd_exp(16'd0));
    step(rd_exp(16'd5));
    run = 1'b0; step(mk_exp(0, 0, 0));

    // init and run together: init only, no issue; then fetch restarts at entry 0
    init = 1'b1; run = 1'b1; inst_in = mk_inst(0, 1, 2'd0, 2'd3, 2'd0, 2'd0, 0, 1);
    step(mk_exp(0, 0, 0));
    step(rd_exp(16'd10));
    run = 1'b0; step(mk_exp(0, 0, 0));

    // Store mux and load return path
    do_reset();
    init = 1'b1; inst_in = mk_inst(0, 1, 2'd0, 2'd1, 2'd0, 2'd2, 0, 0); step(mk_exp(0, 0, 0));
    init = 1'b1; inst_in = mk_inst(0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 1, 1); step(mk_exp(0, 0, 0));
    run = 1'b1;
    e = mk_exp(3'b000, 3'b011, 1'b0);
    e.chk_a = 1'b1; e.a = '0;
    e.chk_s = 1'b1; e.s = 32'h11110000;
    e.chk_l = 1'b1; e.l = 32'hFFFFFFFF; e.lv = 1'b0;
    step(e);
    rd_valid = 1'b1; rd_data = 32'h00001234;
    e = mk_exp(3'b000, 3'b000, 1'b1);
    e.chk_s = 1'b1; e.s = 32'hA5A5A5A5;
    e.chk_l = 1'b1; e.l = 32'h00001234; e.lv = 1'b1;
    step(e);
    run = 1'b0;
    e = mk_exp(0, 0, 0);
    e.chk_s = 1'b1; e.s = 32'h00001234;
    e.chk_l = 1'b1; e.l = 32'h00001234; e.lv = 1'b0;
    step(e);

    // Asynchronous reset while a write request is being issued
    run = 1'b1;
    e = mk_exp(3'b000, 3'b011, 1'b0);
    e.chk_s = 1'b1; e.s = 32'h11110000;
    step(e);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_r_request", 64'(r_request), 64'd0);
    check("midrst_w_request", 64'(w_request), {29'd0, 3'b000, 32'hFFFFFFFF});
    check("midrst_lsu_to_pe", 64'(lsu_to_pe), 64'hFFFFFFFF);
    check("midrst_load_valid", 64'(load_valid), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Program lost after reset: run issues nothing
    e = mk_exp(0, 0, 0);
    e.chk_l = 1'b1; e.l = 32'hFFFFFFFF; e.lv = 1'b0;
    step(e);
    run = 1'b0; step(mk_exp(0, 0, 0));

    @(negedge clk);
    #1;
    check("scoreboard_empty", 64'(sbq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
